// File: rtl/pad_bus_pkg.sv
// Shared definitions for the pad bus responder: size encodings, fault cause
// bit positions, responder states and lane helper functions.
package pad_bus_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b10;
  localparam logic [1:0] SIZE_WORD    = 2'b11;

  localparam int FAULT_MISALIGNED = 0;
  localparam int FAULT_ILLEGAL    = 1;
  localparam int FAULT_OVERRUN    = 2;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESPOND,
    ST_RMW_READ,
    ST_RMW_WRITE
  } responderState_t;

  function automatic logic [31:0] sizeMask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: sizeMask = 32'h0000_00FF;
      SIZE_HALF: sizeMask = 32'h0000_FFFF;
      default:   sizeMask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
    isMisaligned = ((size == SIZE_HALF) && offset[0]) ||
                   ((size == SIZE_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/pad_word_ram.sv
// Single-port word RAM with synchronous write and a registered read port.
module pad_word_ram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clock_i,
  input  logic          writeEnable_i,
  input  logic [AW-1:0] address_i,
  input  logic [31:0]   writeData_i,
  output logic [31:0]   readData_o
);

  logic [31:0] memory [DEPTH_WORDS];
  logic [31:0] readData_q;

  // The read returns the word as it stood before any same-cycle write.
  always_ff @(posedge clock_i) begin
    if (writeEnable_i) begin
      memory[address_i] <= writeData_i;
    end
    readData_q <= memory[address_i];
  end

  assign readData_o = readData_q;

endmodule

// File: rtl/pad_memory_responder.sv
// Memory-side responder for the core pad interface: clears RAM after reset,
// then serves byte/half/word reads and stores with optional wait states.
module pad_memory_responder
  import pad_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS       = 4096,
  parameter int unsigned WAIT_STATES       = 0,
  parameter logic [31:0] RESET_VECTOR_FILL = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  phase,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        pad_read,
  input  logic        pad_write,
  input  logic [1:0]  pad_data_size,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        response_valid,
  output logic        fault,
  output logic [2:0]  fault_cause
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  responderState_t state_q;
  logic [AW-1:0]   clearIndex_q;
  logic [3:0]      waitCount_q;
  logic            reqIsWrite_q;
  logic [1:0]      reqSize_q;
  logic [1:0]      reqOffset_q;
  logic [AW-1:0]   reqIndex_q;
  logic [31:0]     reqData_q;
  logic            reqError_q;
  logic [31:0]     merged_q;
  logic [31:0]     readData_q;
  logic            responseValid_q;
  logic [2:0]      faultCause_q;
  logic [1:0]      phaseCapture_q;

  logic            ramWe;
  logic [AW-1:0]   ramAddr;
  logic [31:0]     ramWdata;
  logic [31:0]     ramRdata;
  logic [4:0]      laneShift;
  logic [31:0]     laneMask;
  logic [31:0]     mergedWord;
  logic [31:0]     extracted;
  logic            request;
  logic            reqMisaligned;
  logic            reqIllegal;

  assign request       = pad_read | pad_write;
  assign reqMisaligned = isMisaligned(pad_data_size, address[1:0]);
  assign reqIllegal    = (pad_data_size == SIZE_ILLEGAL);

  assign laneShift  = {reqOffset_q, 3'b000};
  assign laneMask   = sizeMask(reqSize_q) << laneShift;
  assign mergedWord = (ramRdata & ~laneMask) | ((reqData_q << laneShift) & laneMask);
  assign extracted  = (ramRdata >> laneShift) & sizeMask(reqSize_q);

  // Writes are gated by reset so an aborted store can never reach the RAM.
  always_comb begin
    ramWe    = 1'b0;
    ramAddr  = reqIndex_q;
    ramWdata = reqData_q;
    case (state_q)
      ST_CLEAR: begin
        ramWe    = !reset;
        ramAddr  = clearIndex_q;
        ramWdata = RESET_VECTOR_FILL;
      end
      ST_ACCESS: begin
        ramWe = !reset && reqIsWrite_q && !reqError_q && (reqSize_q == SIZE_WORD);
      end
      ST_RMW_WRITE: begin
        ramWe    = !reset;
        ramWdata = merged_q;
      end
      default: ;
    endcase
  end

  pad_word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clock_i      (clock),
    .writeEnable_i(ramWe),
    .address_i    (ramAddr),
    .writeData_i  (ramWdata),
    .readData_o   (ramRdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_CLEAR;
      clearIndex_q    <= '0;
      waitCount_q     <= '0;
      reqIsWrite_q    <= 1'b0;
      reqSize_q       <= SIZE_WORD;
      reqOffset_q     <= 2'b00;
      reqIndex_q      <= '0;
      reqData_q       <= '0;
      reqError_q      <= 1'b0;
      merged_q        <= '0;
      readData_q      <= '0;
      responseValid_q <= 1'b0;
      faultCause_q    <= '0;
      phaseCapture_q  <= '0;
    end else begin
      responseValid_q <= 1'b0;
      if ((state_q != ST_IDLE) && request) begin
        faultCause_q[FAULT_OVERRUN] <= 1'b1;
        phaseCapture_q              <= phase;
      end
      case (state_q)
        ST_CLEAR: begin
          if (clearIndex_q == AW'(DEPTH_WORDS - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            clearIndex_q <= clearIndex_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (request) begin
            reqIsWrite_q <= pad_write;
            reqSize_q    <= pad_data_size;
            reqOffset_q  <= address[1:0];
            reqIndex_q   <= address[AW+1:2];
            reqData_q    <= write_data;
            reqError_q   <= reqMisaligned | reqIllegal;
            if (reqMisaligned) faultCause_q[FAULT_MISALIGNED] <= 1'b1;
            if (reqIllegal)    faultCause_q[FAULT_ILLEGAL]    <= 1'b1;
            if (pad_read && pad_write) faultCause_q[FAULT_OVERRUN] <= 1'b1;
            waitCount_q <= WAIT_LOAD;
            state_q     <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (waitCount_q == 4'd0) begin
            state_q <= ST_ACCESS;
          end else begin
            waitCount_q <= waitCount_q - 4'd1;
          end
        end
        ST_ACCESS: begin
          if (reqError_q || !reqIsWrite_q || (reqSize_q == SIZE_WORD)) begin
            state_q <= ST_RESPOND;
          end else begin
            state_q <= ST_RMW_READ;
          end
        end
        ST_RESPOND: begin
          responseValid_q <= 1'b1;
          if (reqError_q) begin
            readData_q <= '0;
          end else if (!reqIsWrite_q) begin
            readData_q <= extracted;
          end
          state_q <= ST_IDLE;
        end
        ST_RMW_READ: begin
          merged_q <= mergedWord;
          state_q  <= ST_RMW_WRITE;
        end
        ST_RMW_WRITE: begin
          responseValid_q <= 1'b1;
          state_q         <= ST_IDLE;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  // Upper address bits alias by design; the captured phase is a debug hook only.
  logic unusedSignals;
  assign unusedSignals = ^{address[31:AW+2], phaseCapture_q};

  assign read_data      = readData_q;
  assign ready          = (state_q == ST_IDLE);
  assign response_valid = responseValid_q;
  assign fault_cause    = faultCause_q;
  assign fault          = |faultCause_q;

endmodule

// File: tb/tb_pad_memory_responder.sv
// Directed bench for pad_memory_responder: a zero-wait instance for the main
// function and a three-wait-state instance for latency and dropped requests.
module tb_pad_memory_responder;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BAD  = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  logic        clock;
  logic        reset;
  logic [1:0]  phase;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        padRead;
  logic        padWrite;
  logic [1:0]  padDataSize;
  logic [31:0] readData;
  logic        ready;
  logic        responseValid;
  logic        fault;
  logic [2:0]  faultCause;

  logic [1:0]  phaseW;
  logic [31:0] addressW;
  logic [31:0] writeDataW;
  logic        padReadW;
  logic        padWriteW;
  logic [1:0]  padDataSizeW;
  logic [31:0] readDataW;
  logic        readyW;
  logic        responseValidW;
  logic        faultW;
  logic [2:0]  faultCauseW;

  int checkCount = 0;
  int passCount  = 0;

  pad_memory_responder #(
    .DEPTH_WORDS(4096),
    .WAIT_STATES(0),
    .RESET_VECTOR_FILL(32'h0000_0013)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .phase         (phase),
    .address       (address),
    .write_data    (writeData),
    .pad_read      (padRead),
    .pad_write     (padWrite),
    .pad_data_size (padDataSize),
    .read_data     (readData),
    .ready         (ready),
    .response_valid(responseValid),
    .fault         (fault),
    .fault_cause   (faultCause)
  );

  pad_memory_responder #(
    .DEPTH_WORDS(16),
    .WAIT_STATES(3),
    .RESET_VECTOR_FILL(32'h0000_0013)
  ) u_dutWait (
    .clock         (clock),
    .reset         (reset),
    .phase         (phaseW),
    .address       (addressW),
    .write_data    (writeDataW),
    .pad_read      (padReadW),
    .pad_write     (padWriteW),
    .pad_data_size (padDataSizeW),
    .read_data     (readDataW),
    .ready         (readyW),
    .response_valid(responseValidW),
    .fault         (faultW),
    .fault_cause   (faultCauseW)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  // Issues one request on the zero-wait instance, scrambles the operand
  // inputs right after acceptance, and checks accept-to-response latency.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] data, input int expLatency,
                               output logic [31:0] rdata);
    int waitCycles;
    int latency;
    waitCycles = 0;
    @(negedge clock);
    while (!ready && waitCycles < 50) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!ready) checkOutput({tag, " ready before request"}, 32'(ready), 32'd1);
    address     = addr;
    writeData   = data;
    padDataSize = size;
    padRead     = rd;
    padWrite    = wr;
    @(posedge clock);
    #1;
    padRead     = 1'b0;
    padWrite    = 1'b0;
    address     = ~addr;
    writeData   = ~data;
    padDataSize = SZ_BAD;
    latency = 0;
    while (latency < 20) begin
      latency++;
      @(posedge clock);
      #1;
      if (responseValid) break;
    end
    checkOutput({tag, " latency"}, 32'(latency), 32'(expLatency));
    rdata = readData;
  endtask

  task automatic waitForReady(input string tag, output int cycles);
    cycles = 0;
    while (cycles < 5000) begin
      @(posedge clock);
      #1;
      cycles++;
      if (ready) break;
    end
    if (!ready) checkOutput({tag, " ready timeout"}, 32'(ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rdata;
    int cycles;
    int latency;
    int extra;

    reset = 1'b1;
    phase = 2'b01;
    address = '0;
    writeData = '0;
    padRead = 1'b0;
    padWrite = 1'b0;
    padDataSize = SZ_WORD;
    phaseW = 2'b10;
    addressW = '0;
    writeDataW = '0;
    padReadW = 1'b0;
    padWriteW = 1'b0;
    padDataSizeW = SZ_WORD;

    repeat (4) @(posedge clock);
    @(negedge clock);
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset response_valid", 32'(responseValid), 32'd0);
    checkOutput("reset fault", 32'(fault), 32'd0);
    checkOutput("reset fault_cause", 32'(faultCause), 32'd0);
    checkOutput("reset read_data", readData, 32'd0);
    reset = 1'b0;

    waitForReady("clear", cycles);
    checkOutput("clear duration", 32'(cycles), 32'd4096);

    applyStimulus("rd word 0x40", 1'b1, 1'b0, SZ_WORD, 32'h40, 32'h0, 2, rdata);
    checkOutput("rd word 0x40 data", rdata, 32'h0000_0013);

    applyStimulus("wr word 0x100", 1'b0, 1'b1, SZ_WORD, 32'h100, 32'hDEAD_BEEF, 2, rdata);
    checkOutput("read_data held after write", rdata, 32'h0000_0013);
    applyStimulus("rd byte 0x102", 1'b1, 1'b0, SZ_BYTE, 32'h102, 32'h0, 2, rdata);
    checkOutput("rd byte 0x102 data", rdata, 32'h0000_00AD);
    applyStimulus("rd half 0x100", 1'b1, 1'b0, SZ_HALF, 32'h100, 32'h0, 2, rdata);
    checkOutput("rd half 0x100 data", rdata, 32'h0000_BEEF);
    applyStimulus("rd byte 0x103", 1'b1, 1'b0, SZ_BYTE, 32'h103, 32'h0, 2, rdata);
    checkOutput("rd byte 0x103 data", rdata, 32'h0000_00DE);
    checkOutput("no fault after legal ops", 32'(fault), 32'd0);

    applyStimulus("wr byte 0x101", 1'b0, 1'b1, SZ_BYTE, 32'h101, 32'h0000_005A, 3, rdata);
    applyStimulus("rd after byte store", 1'b1, 1'b0, SZ_WORD, 32'h100, 32'h0, 2, rdata);
    checkOutput("byte store merge", rdata, 32'hDEAD_5AEF);

    applyStimulus("wr half 0x102", 1'b0, 1'b1, SZ_HALF, 32'h102, 32'hFFFF_1234, 3, rdata);
    applyStimulus("rd alias 0x4100", 1'b1, 1'b0, SZ_WORD, 32'h4100, 32'h0, 2, rdata);
    checkOutput("half store merge via alias", rdata, 32'h1234_5AEF);

    applyStimulus("wr word 0x200", 1'b0, 1'b1, SZ_WORD, 32'h200, 32'h1122_3344, 2, rdata);
    applyStimulus("rd word 0x200", 1'b1, 1'b0, SZ_WORD, 32'h200, 32'h0, 2, rdata);
    checkOutput("rd word 0x200 data", rdata, 32'h1122_3344);
    checkOutput("still no fault", 32'(fault), 32'd0);

    applyStimulus("rd half 0x103", 1'b1, 1'b0, SZ_HALF, 32'h103, 32'h0, 2, rdata);
    checkOutput("misaligned read_data", rdata, 32'h0);
    checkOutput("misaligned fault", 32'(fault), 32'd1);
    checkOutput("misaligned cause", 32'(faultCause), 32'b001);
    applyStimulus("wr word misaligned", 1'b0, 1'b1, SZ_WORD, 32'h102, 32'hAAAA_AAAA, 2, rdata);
    applyStimulus("rd after misaligned", 1'b1, 1'b0, SZ_WORD, 32'h100, 32'h0, 2, rdata);
    checkOutput("memory unchanged", rdata, 32'h1234_5AEF);

    applyStimulus("rd illegal size", 1'b1, 1'b0, SZ_BAD, 32'h100, 32'h0, 2, rdata);
    checkOutput("illegal read_data", rdata, 32'h0);
    checkOutput("illegal cause", 32'(faultCause), 32'b011);

    applyStimulus("rd+wr overrun", 1'b1, 1'b1, SZ_WORD, 32'h300, 32'hCAFE_F00D, 2, rdata);
    checkOutput("overrun cause", 32'(faultCause), 32'b111);
    applyStimulus("rd 0x300", 1'b1, 1'b0, SZ_WORD, 32'h300, 32'h0, 2, rdata);
    checkOutput("write wins overrun", rdata, 32'hCAFE_F00D);

    // Wait-state instance: a second read pulsed one cycle after acceptance.
    @(negedge clock);
    checkOutput("wait dut ready", 32'(readyW), 32'd1);
    addressW     = 32'h8;
    padDataSizeW = SZ_WORD;
    padReadW     = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    padReadW = 1'b0;
    addressW = 32'hFFFF_FFFF;
    latency = 1;
    if (!responseValidW) begin
      while (latency < 20) begin
        latency++;
        @(posedge clock);
        #1;
        if (responseValidW) break;
      end
    end
    checkOutput("wait latency", 32'(latency), 32'd5);
    checkOutput("wait read data", readDataW, 32'h0000_0013);
    checkOutput("wait dropped cause", 32'(faultCauseW), 32'b100);
    checkOutput("wait dropped fault", 32'(faultW), 32'd1);
    extra = 0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (responseValidW) extra++;
    end
    checkOutput("dropped request not served", 32'(extra), 32'd0);

    // Reset while a byte store sits in RMW_READ must abort it cleanly.
    @(negedge clock);
    address     = 32'h100;
    writeData   = 32'h0000_0077;
    padDataSize = SZ_BYTE;
    padWrite    = 1'b1;
    @(posedge clock);
    #1;
    padWrite = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    checkOutput("reset mid-op ready", 32'(ready), 32'd0);
    reset = 1'b0;
    waitForReady("reclear", cycles);
    checkOutput("reclear duration", 32'(cycles), 32'd4096);
    checkOutput("fault cleared", 32'(fault), 32'd0);
    checkOutput("cause cleared", 32'(faultCause), 32'd0);
    applyStimulus("rd after abort", 1'b1, 1'b0, SZ_WORD, 32'h100, 32'h0, 2, rdata);
    checkOutput("aborted store not committed", rdata, 32'h0000_0013);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
